// File: rtl/interface_pipeline_sequencer.sv
// Frame sequencer for the front-end interface datapath: loader -> sampler -> sigmoid -> expander/upsampler -> handshake.
// Optional per-stage watchdog compiled in with `define SEQ_WATCHDOG_EN.
module interface_pipeline_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_valid,
    output logic               frame_consume,
    output logic               sampler_start,
    input  logic               sampler_done,
    output logic               vs_start,
    input  logic               vs_done,
    output logic               map_start,
    input  logic               exp_done,
    input  logic               ups_done,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy,
    output logic               error,
    input  logic               clear_error,
    output logic [COUNT_W-1:0] frame_count
);

    // DROP is only reachable when the watchdog discards a sampler frame.
    typedef enum logic [3:0] {
        IDLE, SAMP_GO, SAMP_WAIT, SIG_GO, SIG_WAIT, MAP_GO, MAP_WAIT, HOLD, DROP
    } state_t;

    state_t state;
    logic   exp_seen, ups_seen;
    logic   maps_done;
    logic   timeout;

    assign maps_done = (exp_seen || exp_done) && (ups_seen || ups_done);

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;
    logic            stage_done;

    always_comb begin
        waiting    = (state == SAMP_WAIT) || (state == SIG_WAIT) || (state == MAP_WAIT);
        stage_done = 1'b0;
        case (state)
            SAMP_WAIT: stage_done = sampler_done;
            SIG_WAIT:  stage_done = vs_done;
            MAP_WAIT:  stage_done = maps_done;
            default:   stage_done = 1'b0;
        endcase
        timeout = waiting && !stage_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    end

    // Every WAIT is preceded by a GO state, so the counter is zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          wd_cnt <= '0;
        else if (waiting) wd_cnt <= wd_cnt + 1'b1;
        else              wd_cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              error <= 1'b0;
        else if (timeout)     error <= 1'b1;
        else if (clear_error) error <= 1'b0;
    end
`else
    logic unused_ok;

    assign timeout   = 1'b0;
    assign error     = 1'b0;
    assign unused_ok = clear_error ^ (TIMEOUT_CYCLES < 2);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            exp_seen    <= 1'b0;
            ups_seen    <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE:      if (enable && frame_valid) state <= SAMP_GO;
                SAMP_GO:   state <= SAMP_WAIT;
                SAMP_WAIT: begin
                    if (timeout)           state <= DROP;
                    else if (sampler_done) state <= SIG_GO;
                end
                SIG_GO:    state <= SIG_WAIT;
                SIG_WAIT: begin
                    if (timeout)      state <= IDLE;
                    else if (vs_done) state <= MAP_GO;
                end
                MAP_GO: begin
                    exp_seen <= 1'b0;
                    ups_seen <= 1'b0;
                    state    <= MAP_WAIT;
                end
                MAP_WAIT: begin
                    if (timeout)        state <= IDLE;
                    else if (maps_done) state <= HOLD;
                    if (exp_done) exp_seen <= 1'b1;
                    if (ups_done) ups_seen <= 1'b1;
                end
                HOLD: begin
                    if (result_ready) begin
                        state       <= IDLE;
                        frame_count <= frame_count + 1'b1;
                    end
                end
                DROP:      state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign sampler_start = (state == SAMP_GO);
    assign vs_start      = (state == SIG_GO);
    assign frame_consume = (state == SIG_GO) || (state == DROP);
    assign map_start     = (state == MAP_GO);
    assign result_valid  = (state == HOLD);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_interface_pipeline_sequencer.sv
// Scoreboarded bench: frame schedules push expected output events; a negedge monitor pops and compares them.
module tb_interface_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, frame_valid, frame_consume, sampler_start, sampler_done;
    logic        vs_start, vs_done, map_start, exp_done, ups_done;
    logic        result_valid, result_ready, busy, error, clear_error;
    logic [15:0] frame_count;

    interface_pipeline_sequencer #(.TIMEOUT_CYCLES(16), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
        .frame_consume(frame_consume), .sampler_start(sampler_start), .sampler_done(sampler_done),
        .vs_start(vs_start), .vs_done(vs_done), .map_start(map_start),
        .exp_done(exp_done), .ups_done(ups_done), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .error(error),
        .clear_error(clear_error), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Event bits: samp, vs, consume, map, rv rise, count change, rv fall
    localparam logic [6:0] E_SAMP = 7'h01;
    localparam logic [6:0] E_SIG  = 7'h06;
    localparam logic [6:0] E_CONS = 7'h04;
    localparam logic [6:0] E_MAP  = 7'h08;
    localparam logic [6:0] E_RVR  = 7'h10;
    localparam logic [6:0] E_ACC  = 7'h60;

    typedef struct {
        logic [6:0] bits;
        int         cyc;
        int         cnt;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    bit   mon_en = 1'b1;
    logic rv_prev = 1'b0;
    logic [15:0] cnt_prev = '0;
    logic [6:0]  obs;
    ev_t  e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(logic [6:0] bits, int at, int cnt);
        ev_t n;
        n.bits = bits; n.cyc = at; n.cnt = cnt;
        q.push_back(n);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            obs = {result_valid === 1'b0 && rv_prev, frame_count != cnt_prev,
                   result_valid && !rv_prev, map_start, frame_consume, vs_start, sampler_start};
            while (q.size() != 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_event: got nothing at cycle %0d expected bits %0h", q[0].cyc, q[0].bits);
                void'(q.pop_front());
            end
            if (obs != 7'h0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got bits %0h at cycle %0d expected none", obs, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.bits != obs || e.cyc != cyc || (obs[5] && int'(frame_count) != e.cnt)) begin
                        errors++;
                        $display("FAIL event: got bits %0h cycle %0d count %0d expected bits %0h cycle %0d count %0d",
                                 obs, cyc, frame_count, e.bits, e.cyc, e.cnt);
                    end
                end
            end
        end
        rv_prev  = result_valid;
        cnt_prev = frame_count;
    end

    task automatic clear_pulses();
        sampler_done = 0; vs_done = 0; exp_done = 0; ups_done = 0; result_ready = 0;
    endtask

    // One frame: start request at current cycle c, dones sd/vd after their starts, ed/ud after
    // map_start, result_ready hd cycles after result_valid rises.
    task automatic run_frame(int sd, int vd, int ed, int ud, int hd, bit stray, bit armed);
        int c, s, v, m, h, k;
        c = cyc;
        s = c + 1;
        v = s + sd + 1;
        m = v + vd + 1;
        h = m + ((ed > ud) ? ed : ud) + 1;
        k = h + hd;
        push(E_SAMP, s, 0);
        push(E_SIG, v, 0);
        push(E_MAP, m, 0);
        push(E_RVR, h, 0);
        model_cnt++;
        push(E_ACC, k + 1, model_cnt & 16'hffff);
        for (int t = c; t <= k; t++) begin
            sampler_done = (t == s + sd) || (stray && t == s);
            vs_done      = (t == v + vd) || (stray && (t == s + 1 || t == v));
            exp_done     = (t == m + ed) || (stray && (t == s + 1 || t == m));
            ups_done     = (t == m + ud) || (stray && (t == s + 1 || t == m));
            result_ready = (t == k);
            if (t == c) begin enable = 1; frame_valid = 1; end
            if (t == s) begin
                enable      = armed ? 1'b1 : 1'($urandom % 2);
                frame_valid = armed ? 1'b1 : 1'($urandom % 2);
            end
            if (t == s + 1) chk("busy_in_frame", busy, 1);
            @(negedge clk);
        end
        clear_pulses();
    endtask

    task automatic idle_gap(int n, bit fv);
        for (int i = 0; i < n; i++) begin
            enable = 0; frame_valid = fv;
            chk("busy_idle", busy, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int c;
        rst = 1; enable = 0; frame_valid = 0; clear_error = 0;
        clear_pulses();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_result_valid", result_valid, 0);
        chk("reset_pulses", {sampler_start, vs_start, frame_consume, map_start}, 0);
        chk("reset_error", error, 0);
        chk("reset_count", frame_count, 0);
        rst = 0;
        @(negedge clk);

        // Reset asserted in SIG_WAIT
        c = cyc;
        push(E_SAMP, c + 1, 0);
        push(E_SIG, c + 5, 0);
        for (int t = c; t <= c + 5; t++) begin
            sampler_done = (t == c + 4);
            if (t == c) begin enable = 1; frame_valid = 1; end
            @(negedge clk);
        end
        sampler_done = 0;
        chk("busy_sig_wait", busy, 1);
        rst = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {sampler_start, vs_start, frame_consume, map_start, result_valid}, 0);
        chk("rst_count", frame_count, 0);
        @(negedge clk);
        rst = 0; enable = 0;

        idle_gap(10, 1);                        // enable gating
        run_frame(3, 3, 3, 3, 2, 0, 0);         // nominal
        idle_gap(2, 0);
        run_frame(2, 2, 2, 9, 1, 1, 0);         // skewed mapper dones + stray dones
        idle_gap(1, 1);
        run_frame(3, 3, 3, 3, 20, 0, 1);        // backpressure, back-to-back
        run_frame(3, 3, 3, 3, 20, 0, 1);
        run_frame(3, 3, 3, 3, 20, 0, 0);
        chk("count_after_backpressure", frame_count, model_cnt);
        idle_gap(1, 0);
        for (int i = 0; i < 8; i++) begin
            bit armed;
            armed = 1'($urandom % 2);
            run_frame($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 9),
                      $urandom_range(1, 9), $urandom_range(0, 5), 1'($urandom % 2), armed);
            if (!armed) idle_gap($urandom_range(0, 3), 1'($urandom % 2));
        end

        // Sampler never completes
        c = cyc;
        push(E_SAMP, c + 1, 0);
`ifdef SEQ_WATCHDOG_EN
        push(E_CONS, c + 18, 0);
        for (int t = c; t <= c + 18; t++) begin
            if (t == c)     begin enable = 1; frame_valid = 1; end
            if (t == c + 1) begin enable = 0; frame_valid = 0; end
            @(negedge clk);
        end
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 0);
        chk("wd_count", frame_count, model_cnt);
        clear_error = 1;
        @(negedge clk);
        clear_error = 0;
        chk("wd_clear_error", error, 0);
        repeat (2) @(negedge clk);
`else
        for (int t = c; t <= c + 40; t++) begin
            if (t == c)     begin enable = 1; frame_valid = 1; end
            if (t == c + 1) begin enable = 0; frame_valid = 0; end
            @(negedge clk);
        end
        chk("hang_busy", busy, 1);
        chk("hang_error", error, 0);
        chk("hang_count", frame_count, model_cnt);
        mon_en = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
`endif
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
